// File: rtl/neuromorphic_xn_array.sv
// neuromorphic_xn_array: ROWS x COLS binary-cell crossbar behind an
// EN/R_WB/DI/AD/SEL handshake slave, with configurable write/read latency
// and an in-array MAC op (popcount of DI & one stored column).
// Optional feature macro: NEUROMORPHIC_XN_STATUS_EN turns op 2 into a
// status register {write_count, mac_count}; without it op 2 is reserved.
//
// state  | meaning
// S_IDLE | waiting for EN; captures the request
// S_BUSY | latency countdown; commit happens on the edge leaving this state
// S_ACK  | func_ack high for one cycle, then back to idle
module neuromorphic_xn_array #(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int WR_CYC = 4,
    parameter int RD_CYC = 2
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        EN,
    input  logic        R_WB,
    input  logic [31:0] DI,
    input  logic [31:0] AD,
    input  logic [3:0]  SEL,
    output logic [31:0] DO,
    output logic        func_ack,
    output logic        busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = $clog2(ROWS + 1);
    localparam int LW = $clog2(((WR_CYC > RD_CYC) ? WR_CYC : RD_CYC) + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t state, state_n;

    logic [LW-1:0]   lat_cnt;
    logic [1:0]      cap_op;
    logic            cap_rwb;
    logic [31:0]     cap_di;
    logic [15:0]     cap_idx;
    logic [3:0]      cap_sel;

    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] wmask;
    logic [PW-1:0]   mac_sum;
    logic [31:0]     rd_val;
    logic [RW-1:0]   row_idx;
    logic [CW-1:0]   col_idx;
    logic            row_ok;
    logic            col_ok;
    logic            commit;
    logic            unused_ad_hi;

    assign unused_ad_hi = ^AD[31:18];

    // Range checks use the full 16-bit index so that out-of-range indices
    // never alias onto a real row/column through the truncated address.
    assign row_idx = cap_idx[RW-1:0];
    assign col_idx = cap_idx[CW-1:0];
    assign row_ok  = ({16'd0, cap_idx} < 32'(ROWS));
    assign col_ok  = ({16'd0, cap_idx} < 32'(COLS));
    assign commit  = (state == S_BUSY) && (lat_cnt == '0);

    // State register
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        func_ack = 1'b0;
        case (state)
            S_IDLE: if (EN) state_n = S_BUSY;
            S_BUSY: begin
                busy = 1'b1;
                if (lat_cnt == '0) state_n = S_ACK;
            end
            S_ACK: begin
                busy     = 1'b1;
                func_ack = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Request capture and latency down-counter
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            lat_cnt <= '0;
            cap_op  <= '0;
            cap_rwb <= 1'b0;
            cap_di  <= '0;
            cap_idx <= '0;
            cap_sel <= '0;
        end else if (state == S_IDLE && EN) begin
            cap_op  <= AD[17:16];
            cap_rwb <= R_WB;
            cap_di  <= DI;
            cap_idx <= AD[15:0];
            cap_sel <= SEL;
            // MAC writes are no-ops timed like reads
            lat_cnt <= (!R_WB && AD[17:16] != 2'd1) ? LW'(WR_CYC - 1) : LW'(RD_CYC - 1);
        end else if (state == S_BUSY && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Byte-lane write mask over the row word
    always_comb begin
        wmask = '0;
        for (int c = 0; c < COLS; c++) wmask[c] = cap_sel[c/8];
    end

    // Column popcount of input spikes against stored cells
    always_comb begin
        mac_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (cap_di[r] && mem[r][col_idx]) mac_sum = mac_sum + PW'(1);
        end
    end

`ifdef NEUROMORPHIC_XN_STATUS_EN
    logic [15:0] write_count;
    logic [15:0] mac_count;

    // Saturating activity counters; any op 2 write clears both
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            write_count <= '0;
            mac_count   <= '0;
        end else if (commit) begin
            if (cap_op == 2'd2 && !cap_rwb) begin
                write_count <= '0;
                mac_count   <= '0;
            end else if (cap_op == 2'd0 && !cap_rwb && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end else if (cap_op == 2'd1 && cap_rwb && mac_count != 16'hFFFF) begin
                mac_count <= mac_count + 16'd1;
            end
        end
    end
`endif

    // Read data selection by op
    always_comb begin
        rd_val = '0;
        case (cap_op)
            2'd0: if (row_ok) rd_val = 32'(mem[row_idx]);
            2'd1: if (col_ok) rd_val = 32'(mac_sum);
`ifdef NEUROMORPHIC_XN_STATUS_EN
            2'd2: rd_val = {write_count, mac_count};
`endif
            default: rd_val = '0;
        endcase
    end

    // Cell array: masked row write at commit
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= '0;
        end else if (commit && cap_op == 2'd0 && !cap_rwb && row_ok) begin
            mem[row_idx] <= (mem[row_idx] & ~wmask) | (cap_di[COLS-1:0] & wmask);
        end
    end

    // Read data register; only read commits update it
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin)                DO <= '0;
        else if (commit && cap_rwb) DO <= rd_val;
    end

endmodule

// File: doc/neuromorphic_xn_array.md
# neuromorphic_xn_array

Parametrised next-generation behavioural model of the neuromorphic crossbar macro: a ROWS×COLS binary-cell array behind the same EN/R_WB/DI/AD/SEL/DO/func_ack bus-slave handshake, with configurable write/read latencies. It adds an in-array multiply-accumulate (MAC) mode that returns, for one column, the popcount of an input spike vector ANDed with the stored cells. It sits directly under the Wishbone slave adapter, in the macro's place.

## Interface
- ROWS, 32, array rows; 1..32
- COLS, 32, array columns (row word width); 1..32
- WR_CYC, 4, write latency in cycles; ≥1
- RD_CYC, 2, read/MAC latency in cycles; ≥1
- CLKin  in  1  clock; all logic on rising edge
- RSTin  in  1  reset, asynchronous, active-high
- EN  in  1  request strobe; held by master until func_ack
- R_WB  in  1  1 = read, 0 = write
- DI  in  32  write data / MAC input vector
- AD  in  32  [17:16] op, [15:0] index
- SEL  in  4  byte enables for row writes
- DO  out  32  read data, registered
- func_ack  out  1  one-cycle completion pulse
- busy  out  1  high while a transaction is in flight

## Operation
- FSM: IDLE → BUSY → ACK → IDLE. In IDLE, EN=1 at an edge captures op, R_WB, DI, AD, SEL and loads a latency counter (WR_CYC for writes, RD_CYC otherwise); all inputs are ignored outside IDLE.
- op 0 (row access), row = AD[clog2(ROWS)-1:0]:
  - write: cell bit c updated from DI[c] only if SEL[c/8]=1; DI bits ≥ COLS ignored.
  - read: DO = row word zero-extended to 32 bits.
  - row ≥ ROWS: write is a no-op, read returns 0; acked normally.
- op 1 (MAC), col = AD[clog2(COLS)-1:0], read only: DO = popcount over r<ROWS of (DI[r] & cell[r][col]), zero-extended, width clog2(ROWS+1). col ≥ COLS → 0. MAC with R_WB=0 is a no-op, acked after RD_CYC.
- op 2/3: reserved; reads return 0, writes ignored, acked after RD_CYC/WR_CYC (op 2 under config below).
- DO changes only on read acks; holds across writes and idle.
- Reset mid-transaction: FSM to IDLE, no ack issued, pending write discarded.
- Reset values: DO=0, func_ack=0, busy=0, all cells 0, FSM IDLE.

## Timing
- Capture edge E0 (IDLE, EN=1). busy rises after E0.
- At edge E0+LAT: array write / DO update, func_ack rises; high exactly one cycle.
- At E0+LAT+1: FSM to IDLE, func_ack and busy fall.
- Earliest next capture: E0+LAT+2. EN still high at that edge starts a new transaction (master must drop EN after seeing ack).
- Read-after-write to the same row returns the new data.

## Configuration
- NEUROMORPHIC_XN_STATUS_EN defined: op 2 is a status register. Read returns {write_count[15:0], mac_count[15:0]}; any op 2 write clears both. write_count increments on every acked op 0 write, mac_count on every acked op 1 read; both saturate at 0xFFFF and reset to 0.
- Undefined: op 2 is reserved as above; no counters exist.

## Test plan
- Reset then op 0 read of row 5 → DO=0x0000_0000, func_ack exactly 2 cycles after capture, single cycle wide.
- Write row 3 DI=0xA5A5_5A5A SEL=0xF, then read row 3 → ack 4 cycles after write capture; read DO=0xA5A5_5A5A.
- Write row 3 DI=0xFFFF_FFFF SEL=0x2 over prior 0xA5A5_5A5A → read 0xA5A5_FF5A.
- Rows 0,1,7 hold column 4 =1; MAC col 4 DI=0x0000_0083 → DO=3; DI=0x0000_0002 → DO=1; col 40 → DO=0.
- Assert RSTin two cycles into a write of row 2 → no func_ack, busy=0, later read row 2 returns 0; DI/AD changes during BUSY don't affect result.
- With NEUROMORPHIC_XN_STATUS_EN: 2 writes + 3 MACs, op 2 read → 0x0002_0003; op 2 write, re-read → 0x0000_0000.
